c_detect_pipe: RTL and testbench
================================

Name: c_detect_pipe

Overview:
- Parametrised, pipelined unary (thermometer) code detector and decoder for P_W-bit vectors.
- Classifies each input vector as unary (ones in the low bits, zeros above) or complemented unary (zeros low, ones above), and reports the edge position as a count.
- Splits the bit-serial detection chain across P_STAGES registered segments with valid/ready flow control.
- Sits between a code source (e.g. a thermometer ADC/arbiter front end) and the consumer of the decoded value.

Parameters:
- P_W, 16: input vector width; must be ≥ 2.
- P_STAGES, 4: number of pipeline segments; must divide P_W. Chunk size C = P_W/P_STAGES.
- P_ADMIT_COMPLIMENT_EN, 1: when 0, complemented codes are never admitted; o_is_unary_n is tied to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  input vector valid.
- o_ready  out  1  block can accept an input this cycle.
- i_x  in  P_W  input vector; bit 0 is the first bit of the chain.
- i_cmpl_en  in  1  per-vector runtime enable for complement admission; ANDed with P_ADMIT_COMPLIMENT_EN.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_is_unary  out  1  vector is 1^k 0^(P_W-k), with 0 ≤ k ≤ P_W.
- o_is_unary_n  out  1  vector is 0^k 1^(P_W-k), with 0 < k < P_W.
- o_count  out  $clog2(P_W+1)  the value k. Equals 0 when neither flag is set.
- o_x  out  P_W  the input vector, forwarded unchanged with the result.

Behaviour:
- Reset: all stage valid bits clear.
  - o_valid=0, o_is_unary=0, o_is_unary_n=0, o_count=0, o_x=0.
  - o_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight vectors; nothing is emitted for them.
- Handshake:
  - Input transfer occurs when i_valid & o_ready.
  - Output transfer occurs when o_valid & i_ready.
  - Outputs are held stable while o_valid & ~i_ready.
- Pipeline structure:
  - Stage s (0..P_STAGES-1) holds: valid, the vector, cmpl_en, and carry state.
  - Carry state: all_ones, all_zeros_n, seen_edge, is_unary, is_unary_n, last bit, and partial count.
- Stage advance rule:
  - Stage s loads when it is empty, or when stage s+1 loads (the last stage loads when i_ready).
  - Bubbles collapse.
  - o_ready = stage 0 empty, or stage 0 advancing. This is combinational from i_ready through the chain of stage valids; the path is acceptable.
- Latency: P_STAGES cycles from input transfer to o_valid with no back-pressure. Throughput is 1 vector/cycle.
- Segment evaluation: stage s processes bits [s*C +: C] sequentially, using the carry from stage s-1. Stage 0 uses is_first=1, prev bit=0, is_unary=1, is_unary_n=(cmpl_en & P_ADMIT_COMPLIMENT_EN).
- Per-bit rules:
  - Edge = x ^ prev.
  - A second edge kills both flags.
  - A 1 keeps is_unary only while all prior bits are 1.
  - A 0 keeps is_unary only at or after the first edge.
  - is_unary_n uses the mirrored rules.
  - Count increments on each 1 while all_ones holds (unary), or on each 0 while all-zeros-so-far holds (complement).
- Final resolution (last stage):
  - All zeros: is_unary=1, count=0.
  - All ones: is_unary=1, count=P_W.
  - Otherwise at most one flag is set.
  - Count is forced to 0 if neither flag is set.
- Simultaneous input and output transfer on a full pipeline is sustained without a bubble.

Decomposition:
- Package c_pkg:
  - typedef c_carry_t (packed struct of the carry fields).
  - Parameter function for count width.
  - Constant for the stage-0 carry initialiser.
- Sub-module c_seg: combinational C-bit segment that maps a carry-in plus C bits to a carry-out. It is instantiated P_STAGES times, with registers in the parent.

Test Plan:
- P_W=16, P_STAGES=4, i_ready=1; send 0x00FF then 0x0000 then 0xFFFF.
  - Results 4, 5 and 6 cycles after the first send: is_unary=1 with count 8, 0 and 16.
- Send 0xFF00 with i_cmpl_en=1, then again with i_cmpl_en=0.
  - First: is_unary_n=1, count=8.
  - Second: both flags 0, count=0.
- Non-codes 0x00F7, 0x0F0F and 0x8001: both flags 0, count=0, o_x echoed.
  - The edge crossing a segment boundary (0x000F vs 0x001F) gives counts 4 and 5.
- Stream 8 back-to-back vectors with i_ready low for cycles 3..7.
  - o_ready drops after 4 vectors are accepted.
  - No loss or duplication; outputs stay stable during the stall.
  - Order is preserved.
- Assert rst for 1 cycle with 3 vectors in flight.
  - o_valid=0 the next cycle and none of those vectors are emitted.
  - A vector sent afterwards appears after 4 cycles.
- Build with P_ADMIT_COMPLIMENT_EN=0 and send 0xFFF0 with i_cmpl_en=1: is_unary_n=0, is_unary=0.

Source files
------------

// File: rtl/c_pkg.sv
// Shared types for the unary-code detector: the per-segment carry record,
// the stage-0 carry seed and the output count width helper.
// Latency: n/a (types only). Backpressure: n/a.
package c_pkg;

    // Width of the running count inside the carry record. It is fixed so the
    // struct can be packed, and it bounds the supported vector width to 65535.
    localparam int C_CNT_FIELD_W = 16;

    typedef struct packed {
        logic                     is_first;    // no bit consumed yet
        logic                     last;        // most recent bit consumed
        logic                     all_ones;    // every bit so far was 1
        logic                     all_zeros_n; // every bit so far was 0 (complement path)
        logic                     seen_edge;   // a transition after bit 0 has occurred
        logic                     is_unary;    // still a candidate 1^k 0^m code
        logic                     is_unary_n;  // still a candidate 0^k 1^m code
        logic [C_CNT_FIELD_W-1:0] count;       // length of the leading run
    } c_carry_t;

    // Seed for the first segment; is_unary_n is overwritten with the
    // per-vector complement admission before use.
    localparam c_carry_t C_CARRY_INIT = '{
        is_first:    1'b1,
        last:        1'b0,
        all_ones:    1'b1,
        all_zeros_n: 1'b1,
        seen_edge:   1'b0,
        is_unary:    1'b1,
        is_unary_n:  1'b0,
        count:       '0
    };

    function automatic int c_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/c_seg.sv
// Combinational segment of the unary detector: consumes P_C bits, LSB first,
// and folds them into the carry record. Latency: 0 cycles (pure logic).
// Backpressure: none; the parent registers the result under its own handshake.
//
// Ports:
//   carry_i  carry state entering the segment
//   x_i      the P_C bits belonging to this segment, bit 0 consumed first
//   carry_o  carry state after the last bit of the segment
module c_seg
    import c_pkg::*;
#(
    parameter int P_C = 4
) (
    input  c_carry_t       carry_i,
    input  logic [P_C-1:0] x_i,
    output c_carry_t       carry_o
);

    localparam logic [C_CNT_FIELD_W-1:0] CNT_ONE = {{(C_CNT_FIELD_W-1){1'b0}}, 1'b1};

    always_comb begin : p_chain
        c_carry_t c;
        logic     b;
        logic     edge_b;
        c      = carry_i;
        b      = 1'b0;
        edge_b = 1'b0;
        for (int i = 0; i < P_C; i++) begin
            b      = x_i[i];
            edge_b = b ^ c.last;
            // The transition from the implicit 0 before bit 0 is not an edge;
            // any legal code has at most one real edge.
            if (edge_b && !c.is_first) begin
                if (c.seen_edge) begin
                    c.is_unary   = 1'b0;
                    c.is_unary_n = 1'b0;
                end
                c.seen_edge = 1'b1;
            end
            // A 1 after any 0 breaks 1^k 0^m; a 0 after any 1 breaks 0^k 1^m.
            if (b && !c.all_ones) begin
                c.is_unary = 1'b0;
            end
            if (!b && !c.all_zeros_n) begin
                c.is_unary_n = 1'b0;
            end
            // Only the leading run is counted; which flag survives decides
            // whether that run was ones or zeros.
            if ((b && c.all_ones) || (!b && c.all_zeros_n)) begin
                c.count = c.count + CNT_ONE;
            end
            c.all_ones    = c.all_ones & b;
            c.all_zeros_n = c.all_zeros_n & ~b;
            c.last        = b;
            c.is_first    = 1'b0;
        end
        carry_o = c;
    end

endmodule

// File: rtl/c_detect_pipe.sv
// Pipelined unary / complemented-unary code detector and decoder.
// Latency: P_STAGES cycles from input transfer to o_valid; 1 vector/cycle.
// Backpressure: stages advance only into free space; o_ready is combinational
// from i_ready through the stage valids, bubbles collapse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_valid/o_ready input handshake;  i_x vector (bit 0 first), i_cmpl_en
//                   per-vector complement admission
//   o_valid/i_ready output handshake; o_is_unary (1^k 0^m), o_is_unary_n
//                   (0^k 1^m, 0<k<P_W), o_count = k, o_x = forwarded vector
// P_W must be >= 2 and a multiple of P_STAGES.
module c_detect_pipe
    import c_pkg::*;
#(
    parameter int P_W                   = 16,
    parameter int P_STAGES              = 4,
    parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [P_W-1:0]             i_x,
    input  logic                       i_cmpl_en,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_is_unary,
    output logic                       o_is_unary_n,
    output logic [$clog2(P_W+1)-1:0]   o_count,
    output logic [P_W-1:0]             o_x
);

    localparam int   C     = P_W / P_STAGES;
    localparam int   CNT_W = c_cnt_w(P_W);
    localparam logic ADMIT = (P_ADMIT_COMPLIMENT_EN != 0);
    localparam int   LAST  = P_STAGES - 1;

    // Stage registers and their next-state values.
    logic [P_STAGES-1:0] vld_q, vld_d;
    logic [P_STAGES-1:0] cen_q, cen_d;
    logic [P_W-1:0]      x_q     [P_STAGES];
    logic [P_W-1:0]      x_d     [P_STAGES];
    c_carry_t            carry_q [P_STAGES];
    c_carry_t            carry_d [P_STAGES];

    // What each stage would capture if it loads this cycle.
    logic [P_STAGES-1:0] in_vld;
    logic [P_STAGES-1:0] in_cen;
    logic [P_W-1:0]      in_x      [P_STAGES];
    c_carry_t            seg_carry [P_STAGES];

    // Stage s may load when it or any stage downstream of it has a hole, or
    // when the output is being taken. Written flat rather than as a ripple so
    // there is no self-referencing combinational vector.
    logic [P_STAGES-1:0] load;

    for (genvar s = 0; s < P_STAGES; s++) begin : g_stage
        assign load[s] = i_ready | ~(&vld_q[LAST:s]);

        if (s == 0) begin : g_first
            c_carry_t init_c;
            always_comb begin
                init_c            = C_CARRY_INIT;
                init_c.is_unary_n = i_cmpl_en & ADMIT;
            end
            assign in_vld[s] = i_valid;
            assign in_cen[s] = i_cmpl_en;
            assign in_x[s]   = i_x;
            c_seg #(.P_C(C)) u_seg (
                .carry_i (init_c),
                .x_i     (i_x[0 +: C]),
                .carry_o (seg_carry[s])
            );
        end else begin : g_next
            assign in_vld[s] = vld_q[s-1];
            assign in_cen[s] = cen_q[s-1];
            assign in_x[s]   = x_q[s-1];
            c_seg #(.P_C(C)) u_seg (
                .carry_i (carry_q[s-1]),
                .x_i     (x_q[s-1][s*C +: C]),
                .carry_o (seg_carry[s])
            );
        end
    end

    assign o_ready = load[0];

    always_comb begin
        vld_d = vld_q;
        cen_d = cen_q;
        for (int s = 0; s < P_STAGES; s++) begin
            x_d[s]     = x_q[s];
            carry_d[s] = carry_q[s];
        end
        for (int s = 0; s < P_STAGES; s++) begin
            if (load[s]) begin
                vld_d[s] = in_vld[s];
                // Payload only moves with a real vector; bubbles leave it be.
                if (in_vld[s]) begin
                    cen_d[s]   = in_cen[s];
                    x_d[s]     = in_x[s];
                    carry_d[s] = seg_carry[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cen_q <= '0;
            for (int s = 0; s < P_STAGES; s++) begin
                x_q[s]     <= '0;
                carry_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cen_q <= cen_d;
            for (int s = 0; s < P_STAGES; s++) begin
                x_q[s]     <= x_d[s];
                carry_q[s] <= carry_d[s];
            end
        end
    end

    // Final resolution on the last stage. After reset the carry is all-zero,
    // so none of the overrides fire and every output reads 0.
    c_carry_t             fin;
    logic                 res_u;
    logic                 res_un;
    logic [CNT_W-1:0]     res_cnt;

    assign fin = carry_q[LAST];

    always_comb begin
        res_u   = fin.is_unary;
        res_un  = fin.is_unary_n & cen_q[LAST] & ADMIT;
        res_cnt = fin.count[CNT_W-1:0];
        if (fin.all_zeros_n) begin
            // 0^P_W is the k=0 unary code, not a complemented one.
            res_u   = 1'b1;
            res_un  = 1'b0;
            res_cnt = '0;
        end else if (fin.all_ones) begin
            // 1^P_W: count already equals P_W; the complement candidate
            // never saw a 0 and must be dropped.
            res_u   = 1'b1;
            res_un  = 1'b0;
        end
        if (!res_u && !res_un) begin
            res_cnt = '0;
        end
    end

    assign o_valid      = vld_q[LAST];
    assign o_is_unary   = res_u;
    assign o_is_unary_n = res_un;
    assign o_count      = res_cnt;
    assign o_x          = x_q[LAST];

    logic unused_fin;
    assign unused_fin = ^{fin.is_first, fin.last, fin.seen_edge, fin.count};

endmodule

// File: tb/tb_c_detect_pipe.sv
module tb_c_detect_pipe;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_cmpl_en = 1'b0;
    logic          i_ready = 1'b1;
    logic [W-1:0]  i_x = '0;

    logic          o_ready, o_valid, o_is_unary, o_is_unary_n;
    logic [CW-1:0] o_count;
    logic [W-1:0]  o_x;
    logic          n_ready, n_valid, n_u, n_un;
    logic [CW-1:0] n_count;
    logic [W-1:0]  n_x;

    always #5 clk = ~clk;

    c_detect_pipe #(.P_W(W), .P_STAGES(4), .P_ADMIT_COMPLIMENT_EN(1)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_x(i_x),
        .i_cmpl_en(i_cmpl_en), .o_valid(o_valid), .i_ready(i_ready),
        .o_is_unary(o_is_unary), .o_is_unary_n(o_is_unary_n), .o_count(o_count), .o_x(o_x)
    );

    c_detect_pipe #(.P_W(W), .P_STAGES(4), .P_ADMIT_COMPLIMENT_EN(0)) dut_nc (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(n_ready), .i_x(i_x),
        .i_cmpl_en(i_cmpl_en), .o_valid(n_valid), .i_ready(i_ready),
        .o_is_unary(n_u), .o_is_unary_n(n_un), .o_count(n_count), .o_x(n_x)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rand_rdy = 0;

    always @(posedge clk) cyc++;

    typedef struct packed {
        logic          u;
        logic          un;
        logic [CW-1:0] cnt;
    } res_t;

    typedef struct {
        logic [W-1:0] x;
        logic         cen;
        res_t         r;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb[$];

    // Reference: a vector is unary iff it equals 2^k-1 for its leading-ones
    // length k; complemented iff it equals the 16-bit mask shifted by its
    // leading-zeros length z with 0<z<W.
    function automatic res_t ref_model(input logic [W-1:0] x, input logic cen, input bit admit);
        int          k;
        int          z;
        logic [31:0] xv;
        res_t        r;
        k  = 0;
        z  = 0;
        xv = {16'd0, x};
        r  = '0;
        while (k < W && x[k]) k++;
        while (z < W && !x[z]) z++;
        if (xv == (32'd1 << k) - 32'd1) begin
            r.u   = 1'b1;
            r.cnt = CW'(k);
        end else if (admit && cen && z > 0 && z < W && xv == ((32'hFFFF << z) & 32'hFFFF)) begin
            r.un  = 1'b1;
            r.cnt = CW'(z);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] x, input logic cen, input res_t r, input bit lat);
        exp_t e;
        e.x = x; e.cen = cen; e.r = r; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    // Called aligned just after a rising edge; returns just after the edge
    // that transferred the vector.
    task automatic send(input logic [W-1:0] x, input logic cen, input res_t r, input bit lat);
        int t;
        t = 0;
        i_valid = 1'b1; i_x = x; i_cmpl_en = cen;
        if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        while (!o_ready && t < 100) begin
            @(posedge clk); #1;
            if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("send_timeout", 32'(o_ready), 32'd1);
        else push(x, cen, r, lat);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Output monitor: scoreboard pop on every output transfer, hold check on
    // every stalled cycle.
    logic          stall_q = 1'b0;
    logic [W-1:0]  hx;
    logic          hu, hun;
    logic [CW-1:0] hc;

    always @(negedge clk) begin
        exp_t e;
        res_t rn;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_vld", 32'(o_valid), 32'd1);
                check("stall_x",   32'(o_x),     32'(hx));
                check("stall_u",   32'(o_is_unary),   32'(hu));
                check("stall_un",  32'(o_is_unary_n), 32'(hun));
                check("stall_cnt", 32'(o_count), 32'(hc));
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(o_valid), 32'd0);
                end else begin
                    e  = sb.pop_front();
                    rn = ref_model(e.x, e.cen, 1'b0);
                    check("out_x",   32'(o_x),          32'(e.x));
                    check("out_u",   32'(o_is_unary),   32'(e.r.u));
                    check("out_un",  32'(o_is_unary_n), 32'(e.r.un));
                    check("out_cnt", 32'(o_count),      32'(e.r.cnt));
                    check("nc_vld",  32'(n_valid),      32'd1);
                    check("nc_x",    32'(n_x),          32'(e.x));
                    check("nc_u",    32'(n_u),          32'(rn.u));
                    check("nc_un",   32'(n_un),         32'(rn.un));
                    check("nc_cnt",  32'(n_count),      32'(rn.cnt));
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'd4);
                end
            end
            stall_q = o_valid && !i_ready;
            hx  = o_x;
            hu  = o_is_unary;
            hun = o_is_unary_n;
            hc  = o_count;
        end
    end

    initial begin
        logic [W-1:0] sv [8];
        logic [W-1:0] x;
        logic         cen;
        int           idx;
        int           k;
        int           t;

        sv = '{16'h0001, 16'h0003, 16'hFFF8, 16'h00FF, 16'h1234, 16'h7FFF, 16'hFFFE, 16'h0000};

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_vld",   32'(o_valid),      32'd0);
        check("rst_rdy",   32'(o_ready),      32'd1);
        check("rst_u",     32'(o_is_unary),   32'd0);
        check("rst_un",    32'(o_is_unary_n), 32'd0);
        check("rst_cnt",   32'(o_count),      32'd0);
        check("rst_x",     32'(o_x),          32'd0);
        check("rst_nc_rdy", 32'(n_ready),     32'd1);
        @(posedge clk); #1;

        // Back-to-back unary codes with latency check.
        send(16'h00FF, 1'b0, '{u:1'b1, un:1'b0, cnt:5'd8},  1'b1);
        send(16'h0000, 1'b0, '{u:1'b1, un:1'b0, cnt:5'd0},  1'b1);
        send(16'hFFFF, 1'b0, '{u:1'b1, un:1'b0, cnt:5'd16}, 1'b1);
        wait_drain();

        // Complemented codes, admitted and refused.
        send(16'hFF00, 1'b1, '{u:1'b0, un:1'b1, cnt:5'd8}, 1'b0);
        send(16'hFF00, 1'b0, '{u:1'b0, un:1'b0, cnt:5'd0}, 1'b0);
        // Non-codes and an edge crossing a segment boundary.
        send(16'h00F7, 1'b1, '{u:1'b0, un:1'b0, cnt:5'd0}, 1'b0);
        send(16'h0F0F, 1'b1, '{u:1'b0, un:1'b0, cnt:5'd0}, 1'b0);
        send(16'h8001, 1'b1, '{u:1'b0, un:1'b0, cnt:5'd0}, 1'b0);
        send(16'h000F, 1'b0, '{u:1'b1, un:1'b0, cnt:5'd4}, 1'b0);
        send(16'h001F, 1'b0, '{u:1'b1, un:1'b0, cnt:5'd5}, 1'b0);
        // Admitted on the main instance; the no-complement build must refuse.
        send(16'hFFF0, 1'b1, '{u:1'b0, un:1'b1, cnt:5'd4}, 1'b0);
        wait_drain();

        // Streaming with a downstream stall on cycles 3..7.
        idx = 0;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            i_ready = !(c >= 3 && c <= 7);
            i_valid = 1'b1; i_x = sv[idx]; i_cmpl_en = 1'b1;
            @(negedge clk);
            if (c == 4) begin
                check("stall_ordy",     32'(o_ready), 32'd0);
                check("stall_accepted", 32'(idx),     32'd4);
            end
            if (c == 8) check("full_flow_ordy", 32'(o_ready), 32'd1);
            if (o_ready) begin
                push(sv[idx], 1'b1, ref_model(sv[idx], 1'b1, 1'b1), 1'b0);
                idx++;
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        if (idx < 8) check("stall_stream_done", 32'(idx), 32'd8);
        wait_drain();

        // Reset with three vectors in flight.
        send(16'h0007, 1'b0, '{u:1'b1, un:1'b0, cnt:5'd3}, 1'b0);
        send(16'h003F, 1'b0, '{u:1'b1, un:1'b0, cnt:5'd6}, 1'b0);
        send(16'hF000, 1'b1, '{u:1'b0, un:1'b1, cnt:5'd12}, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_vld", 32'(o_valid), 32'd0);
        check("midrst_rdy", 32'(o_ready), 32'd1);
        check("midrst_x",   32'(o_x),     32'd0);
        @(posedge clk); #1;
        send(16'h01FF, 1'b0, '{u:1'b1, un:1'b0, cnt:5'd9}, 1'b1);
        wait_drain();

        // Randomised mix against the reference model, random backpressure.
        rand_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            t = $urandom_range(0, 3);
            case (t)
                0: begin
                    k = $urandom_range(0, 16);
                    x = W'((32'd1 << k) - 32'd1);
                end
                1: begin
                    k = $urandom_range(1, 15);
                    x = W'(32'hFFFF << k);
                end
                2: x = W'($urandom);
                default: begin
                    k = $urandom_range(0, 16);
                    x = W'((32'd1 << k) - 32'd1) ^ W'(32'd1 << $urandom_range(0, 15));
                end
            endcase
            cen = 1'($urandom_range(0, 1));
            send(x, cen, ref_model(x, cen, 1'b1), 1'b0);
        end
        rand_rdy = 0;
        i_ready  = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
